// File: rtl/fwd_src_pipe_pkg.sv
// Shared definitions for the forwarding-source pipeline: result classes, MIPS opcode/funct
// constants and the link register index. Reused by the hazard unit's own decode.
package fwd_src_pipe_pkg;

    typedef enum logic [1:0] {
        RES_NW  = 2'b00,
        RES_ALU = 2'b01,
        RES_DM  = 2'b10,
        RES_PC  = 2'b11
    } res_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [4:0] REG_RA   = 5'd31;

    // Cycles until the result exists, counted from entry into E.
    function automatic logic [1:0] tnew_of(res_t r);
        case (r)
            RES_ALU: return 2'd1;
            RES_DM:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fwd_src_pipe_if.sv
// Signal bundle between the datapath and the forwarding-source pipeline.
// FWD_TNEW_EN adds the tnew_e/tnew_m tags used by the hazard unit.
interface fwd_src_pipe_if
    import fwd_src_pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic [DW-1:0] ir_d;
    logic [DW-1:0] pc8_d;
    logic          stall;
    logic [DW-1:0] ao_e;
    logic [DW-1:0] dr_m;

    logic [RW-1:0] a3_e;
    res_t          res_e;
    logic [RW-1:0] a3_m;
    res_t          res_m;
    logic [DW-1:0] pc8_m;
    logic [DW-1:0] ao_m;
    logic [RW-1:0] a3_w;
    res_t          res_w;
    logic [DW-1:0] pc8_w;
    logic [DW-1:0] ao_w;
    logic [DW-1:0] dr_w;
    logic [DW-1:0] wd_w;
    logic          we_w;
`ifdef FWD_TNEW_EN
    logic [1:0]    tnew_e;
    logic [1:0]    tnew_m;
`endif

    modport master (
`ifdef FWD_TNEW_EN
        input  tnew_e, tnew_m,
`endif
        output ir_d, pc8_d, stall, ao_e, dr_m,
        input  a3_e, res_e, a3_m, res_m, pc8_m, ao_m,
        input  a3_w, res_w, pc8_w, ao_w, dr_w, wd_w, we_w
    );

    modport slave (
`ifdef FWD_TNEW_EN
        output tnew_e, tnew_m,
`endif
        input  ir_d, pc8_d, stall, ao_e, dr_m,
        output a3_e, res_e, a3_m, res_m, pc8_m, ao_m,
        output a3_w, res_w, pc8_w, ao_w, dr_w, wd_w, we_w
    );

endinterface

// File: rtl/fwd_src_pipe_res_decode.sv
// Combinational instruction -> {write destination, result class[, tnew]} decode.
// FWD_TNEW_EN adds the tnew output.
module fwd_src_pipe_res_decode
    import fwd_src_pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [DW-1:0] ir,
`ifdef FWD_TNEW_EN
    output logic [1:0]    tnew,
`endif
    output logic [RW-1:0] a3,
    output res_t          res
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] a3_raw;
    res_t       res_raw;
    logic       unused_fields;

    assign opcode        = ir[31:26];
    assign rt            = ir[20:16];
    assign rd            = ir[15:11];
    assign funct         = ir[5:0];
    assign unused_fields = ^{ir[25:21], ir[10:6]};

    always_comb begin
        a3_raw  = '0;
        res_raw = RES_NW;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JALR) begin
                    a3_raw  = rd;
                    res_raw = RES_PC;
                end else if (funct != FN_JR) begin
                    a3_raw  = rd;
                    res_raw = RES_ALU;
                end
            end
            OP_ORI, OP_LUI, OP_ADDIU, OP_ADDI, OP_ANDI, OP_SLTI: begin
                a3_raw  = rt;
                res_raw = RES_ALU;
            end
            OP_LW: begin
                a3_raw  = rt;
                res_raw = RES_DM;
            end
            OP_JAL: begin
                a3_raw  = REG_RA;
                res_raw = RES_PC;
            end
            default: ;
        endcase
    end

    // $0 is hard-wired, so a write to it must never look like a forwardable result.
    assign a3  = (a3_raw == '0) ? '0 : RW'(a3_raw);
    assign res = (a3_raw == '0) ? RES_NW : res_raw;

`ifdef FWD_TNEW_EN
    assign tnew = tnew_of(res);
`endif

endmodule

// File: rtl/fwd_src_pipe.sv
// Producer side of operand forwarding: D/E, E/M and M/W tag/data registers plus the
// regfile write-data mux. FWD_TNEW_EN adds the tnew_e/tnew_m tags.
module fwd_src_pipe
    import fwd_src_pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic         clk,
    input  logic         reset,
    fwd_src_pipe_if.slave bus
);
    typedef struct packed {
        logic [RW-1:0] a3;
        res_t          res;
        logic [DW-1:0] pc8;
    } e_stage_t;

    typedef struct packed {
        logic [RW-1:0] a3;
        res_t          res;
        logic [DW-1:0] pc8;
        logic [DW-1:0] ao;
    } m_stage_t;

    typedef struct packed {
        logic [RW-1:0] a3;
        res_t          res;
        logic [DW-1:0] pc8;
        logic [DW-1:0] ao;
        logic [DW-1:0] dr;
    } w_stage_t;

    logic [RW-1:0] dec_a3;
    res_t          dec_res;
    e_stage_t      e_q;
    m_stage_t      m_q;
    w_stage_t      w_q;
    logic [DW-1:0] wd;

`ifdef FWD_TNEW_EN
    logic [1:0]    dec_tnew;
    logic [1:0]    tnew_e_q;
    logic [1:0]    tnew_m_q;
`endif

    fwd_src_pipe_res_decode #(.DW(DW), .RW(RW)) u_dec (
        .ir   (bus.ir_d),
`ifdef FWD_TNEW_EN
        .tnew (dec_tnew),
`endif
        .a3   (dec_a3),
        .res  (dec_res)
    );

    // Stall only bubbles E; M and W keep draining so older results still reach the regfile.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            if (bus.stall) e_q <= '0;
            else           e_q <= '{a3: dec_a3, res: dec_res, pc8: bus.pc8_d};
            m_q <= '{a3: e_q.a3, res: e_q.res, pc8: e_q.pc8, ao: bus.ao_e};
            w_q <= '{a3: m_q.a3, res: m_q.res, pc8: m_q.pc8, ao: m_q.ao, dr: bus.dr_m};
        end
    end

`ifdef FWD_TNEW_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tnew_e_q <= '0;
            tnew_m_q <= '0;
        end else begin
            tnew_e_q <= bus.stall ? 2'd0 : dec_tnew;
            tnew_m_q <= (tnew_e_q != 2'd0) ? tnew_e_q - 2'd1 : 2'd0;
        end
    end

    assign bus.tnew_e = tnew_e_q;
    assign bus.tnew_m = tnew_m_q;
`endif

    always_comb begin
        wd = '0;
        case (w_q.res)
            RES_ALU: wd = w_q.ao;
            RES_DM:  wd = w_q.dr;
            RES_PC:  wd = w_q.pc8;
            default: wd = '0;
        endcase
    end

    assign bus.a3_e  = e_q.a3;
    assign bus.res_e = e_q.res;
    assign bus.a3_m  = m_q.a3;
    assign bus.res_m = m_q.res;
    assign bus.pc8_m = m_q.pc8;
    assign bus.ao_m  = m_q.ao;
    assign bus.a3_w  = w_q.a3;
    assign bus.res_w = w_q.res;
    assign bus.pc8_w = w_q.pc8;
    assign bus.ao_w  = w_q.ao;
    assign bus.dr_w  = w_q.dr;
    assign bus.wd_w  = wd;
    assign bus.we_w  = (w_q.res != RES_NW);

endmodule

// File: tb/tb_fwd_src_pipe.sv
// Scoreboard bench for fwd_src_pipe: directed cases then random instruction streams,
// expectations derived from the input history of every cycle.
module tb_fwd_src_pipe;
    import fwd_src_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fwd_src_pipe_if #(.DW(32), .RW(5)) bus ();

    fwd_src_pipe #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] ir, pc8, ao, dr;
        logic        stall, rst;
    } rec_t;

    typedef struct {
        logic [4:0]  a3;
        logic [1:0]  res;
        logic [31:0] pc8, ao, dr;
        logic [1:0]  tnew;
    } tag_t;

    typedef struct {
        tag_t        e, m, w;
        logic [31:0] wd;
        logic        we;
    } exp_t;

    rec_t hist[$];
    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] NOP = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic tag_t zero_tag();
        tag_t t;
        t = '{a3: 5'd0, res: 2'd0, pc8: 32'd0, ao: 32'd0, dr: 32'd0, tnew: 2'd0};
        return t;
    endfunction

    // Instruction semantics: who writes which register, and with what kind of result.
    function automatic tag_t ref_decode(logic [31:0] ir);
        tag_t       t;
        logic [5:0] op, fn;
        t  = zero_tag();
        op = ir[31:26];
        fn = ir[5:0];
        if (op == 6'h00 && fn == 6'h09) begin t.a3 = ir[15:11]; t.res = 2'b11; end
        else if (op == 6'h00 && fn != 6'h08) begin t.a3 = ir[15:11]; t.res = 2'b01; end
        else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F}) begin t.a3 = ir[20:16]; t.res = 2'b01; end
        else if (op == 6'h23) begin t.a3 = ir[20:16]; t.res = 2'b10; end
        else if (op == 6'h03) begin t.a3 = 5'd31; t.res = 2'b11; end
        if (t.a3 == 5'd0) t.res = 2'b00;
        t.tnew = (t.res == 2'b01) ? 2'd1 : (t.res == 2'b10) ? 2'd2 : 2'd0;
        return t;
    endfunction

    // Contents of each stage after edge n, expressed through the cycle history.
    function automatic tag_t etag(int n);
        tag_t t;
        t = zero_tag();
        if (n < 0 || hist[n].rst || hist[n].stall) return t;
        t     = ref_decode(hist[n].ir);
        t.pc8 = hist[n].pc8;
        return t;
    endfunction

    function automatic tag_t mtag(int n);
        tag_t t;
        t = zero_tag();
        if (n < 0 || hist[n].rst) return t;
        t      = etag(n - 1);
        t.tnew = (t.tnew > 2'd0) ? t.tnew - 2'd1 : 2'd0;
        t.ao   = hist[n].ao;
        return t;
    endfunction

    function automatic tag_t wtag(int n);
        tag_t t;
        t = zero_tag();
        if (n < 0 || hist[n].rst) return t;
        t    = mtag(n - 1);
        t.dr = hist[n].dr;
        return t;
    endfunction

    // Apply one cycle of inputs, queue what the outputs must be after the coming edge.
    task automatic step(input logic [31:0] ir, input logic [31:0] pc8, input logic stall,
                        input logic [31:0] ao, input logic [31:0] dr, input logic rst);
        rec_t r;
        exp_t x;
        int   n;
        bus.ir_d  = ir;
        bus.pc8_d = pc8;
        bus.stall = stall;
        bus.ao_e  = ao;
        bus.dr_m  = dr;
        reset     = rst;
        r = '{ir: ir, pc8: pc8, ao: ao, dr: dr, stall: stall, rst: rst};
        hist.push_back(r);
        n   = hist.size() - 1;
        x.e = etag(n);
        x.m = mtag(n);
        x.w = wtag(n);
        case (x.w.res)
            2'b01:   x.wd = x.w.ao;
            2'b10:   x.wd = x.w.dr;
            2'b11:   x.wd = x.w.pc8;
            default: x.wd = 32'd0;
        endcase
        x.we = (x.w.res != 2'b00);
        sbq.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] ao, input logic [31:0] dr);
        step(NOP, 32'd0, 1'b0, ao, dr, 1'b0);
    endtask

    // Monitor: compares every cycle's outputs against the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("a3_e",  32'(bus.a3_e),  32'(x.e.a3));
                chk("res_e", 32'(bus.res_e), 32'(x.e.res));
                chk("a3_m",  32'(bus.a3_m),  32'(x.m.a3));
                chk("res_m", 32'(bus.res_m), 32'(x.m.res));
                chk("pc8_m", bus.pc8_m,      x.m.pc8);
                chk("ao_m",  bus.ao_m,       x.m.ao);
                chk("a3_w",  32'(bus.a3_w),  32'(x.w.a3));
                chk("res_w", 32'(bus.res_w), 32'(x.w.res));
                chk("pc8_w", bus.pc8_w,      x.w.pc8);
                chk("ao_w",  bus.ao_w,       x.w.ao);
                chk("dr_w",  bus.dr_w,       x.w.dr);
                chk("wd_w",  bus.wd_w,       x.wd);
                chk("we_w",  32'(bus.we_w),  32'(x.we));
`ifdef FWD_TNEW_EN
                chk("tnew_e", 32'(bus.tnew_e), 32'(x.e.tnew));
                chk("tnew_m", 32'(bus.tnew_m), 32'(x.m.tnew));
`endif
            end
        end
    end

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [5:0]  iops [6];
        logic [15:0] imm;
        iops = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
        imm  = 16'($urandom);
        case ($urandom_range(0, 12))
            0, 1: return {6'h00, rreg(), rreg(), rreg(), 5'd0, 6'h21};
            2:    return {6'h00, rreg(), 15'd0, 6'h08};
            3:    return {6'h00, rreg(), 5'd0, rreg(), 5'd0, 6'h09};
            4, 5: return {iops[$urandom_range(0, 5)], rreg(), rreg(), imm};
            6, 7: return {6'h23, rreg(), rreg(), imm};
            8:    return {6'h2B, rreg(), rreg(), imm};
            9:    return {6'h04, rreg(), rreg(), imm};
            10:   return {($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles: everything cleared.
        step(32'hFFFF_FFFF, 32'h1111_1111, 1'b0, 32'h2222_2222, 32'h3333_3333, 1'b1);
        step(32'h8C85_0000, 32'h4444_4444, 1'b1, 32'h5555_5555, 32'h6666_6666, 1'b1);
        chk("rst_res_w", 32'(bus.res_w), 32'd0);
        chk("rst_wd_w",  bus.wd_w,       32'd0);
        chk("rst_we_w",  32'(bus.we_w),  32'd0);
        chk("rst_pc8_m", bus.pc8_m,      32'd0);

        // addu $3,$1,$2
        step(32'h0022_1821, 32'h3004, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("addu_a3_e",  32'(bus.a3_e),  32'd3);
        chk("addu_res_e", 32'(bus.res_e), 32'd1);
`ifdef FWD_TNEW_EN
        chk("addu_tnew_e", 32'(bus.tnew_e), 32'd1);
`endif
        idle(32'h1234, 32'h0);
        chk("addu_a3_m", 32'(bus.a3_m), 32'd3);
        chk("addu_ao_m", bus.ao_m,      32'h1234);
`ifdef FWD_TNEW_EN
        chk("addu_tnew_m", 32'(bus.tnew_m), 32'd0);
`endif
        idle(32'h0, 32'h0);
        chk("addu_res_w", 32'(bus.res_w), 32'd1);
        chk("addu_wd_w",  bus.wd_w,       32'h1234);
        chk("addu_we_w",  32'(bus.we_w),  32'd1);

        // lw $5,0($4)
        step(32'h8C85_0000, 32'h3010, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef FWD_TNEW_EN
        chk("lw_tnew_e", 32'(bus.tnew_e), 32'd2);
`endif
        idle(32'h40, 32'h0);
        chk("lw_res_m", 32'(bus.res_m), 32'd2);
`ifdef FWD_TNEW_EN
        chk("lw_tnew_m", 32'(bus.tnew_m), 32'd1);
`endif
        idle(32'h0, 32'hDEAD_BEEF);
        chk("lw_res_w", 32'(bus.res_w), 32'd2);
        chk("lw_wd_w",  bus.wd_w,       32'hDEAD_BEEF);

        // jal
        step(32'h0C00_0100, 32'h3008, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("jal_a3_e",  32'(bus.a3_e),  32'd31);
        chk("jal_res_e", 32'(bus.res_e), 32'd3);
        idle(32'h77, 32'h0);
        idle(32'h0, 32'h88);
        chk("jal_pc8_w", bus.pc8_w, 32'h3008);
        chk("jal_wd_w",  bus.wd_w,  32'h3008);

        // ori $0,$1,5 then sw: no destination anywhere
        step(32'h3420_0005, 32'h3020, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("ori0_res_e", 32'(bus.res_e), 32'd0);
        chk("ori0_a3_e",  32'(bus.a3_e),  32'd0);
        step(32'hAC41_0000, 32'h3024, 1'b0, 32'h5, 32'h0, 1'b0);
        chk("sw_res_e", 32'(bus.res_e), 32'd0);
        idle(32'h9, 32'h0);
        chk("ori0_we_w", 32'(bus.we_w), 32'd0);
        idle(32'h0, 32'h0);
        chk("sw_we_w", 32'(bus.we_w), 32'd0);

        // lw in E while stall asserted: bubble into E, lw advances to M
        step(32'h8C85_0000, 32'h3030, 1'b0, 32'h0, 32'h0, 1'b0);
        step(32'h0022_1821, 32'h3034, 1'b1, 32'hAB, 32'h0, 1'b0);
        chk("stall_res_e", 32'(bus.res_e), 32'd0);
        chk("stall_a3_e",  32'(bus.a3_e),  32'd0);
        chk("stall_res_m", 32'(bus.res_m), 32'd2);
        chk("stall_a3_m",  32'(bus.a3_m),  32'd5);
        // back-to-back stall, then reset together with stall
        step(32'h0022_1821, 32'h3034, 1'b1, 32'hAC, 32'h0, 1'b0);
        step(32'h0022_1821, 32'h3034, 1'b1, 32'hAD, 32'h1, 1'b1);
        chk("rst_stall_res_m", 32'(bus.res_m), 32'd0);
        chk("rst_stall_res_w", 32'(bus.res_w), 32'd0);
        chk("rst_stall_dr_w",  bus.dr_w,       32'd0);

        // Random streams with occasional stalls and resets.
        for (int i = 0; i < 600; i++) begin
            step(rand_ir(), $urandom, ($urandom_range(0, 5) == 0), $urandom, $urandom,
                 ($urandom_range(0, 59) == 0));
        end
        idle(32'h0, 32'h0);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
